scan_code_history: RTL and testbench

SCAN_CODE_HISTORY -- requirements
Module: scan_code_history

---
 rtl/scan_code_history_if.sv | 32 +++
 rtl/scan_code_history.sv | 120 ++++++++++++
 tb/tb_scan_code_history.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/scan_code_history_if.sv
// Bus bundle for scan_code_history: code strobe/clear in, history and release status out.
// master = code source / history consumer, slave = scan_code_history itself.
interface scan_code_history_if #(
    parameter int DEPTH = 6,
    parameter int WIDTH = 8
);
    localparam int CW = $clog2(DEPTH + 1);

    logic                          code_valid;
    logic [WIDTH-1:0]              data_in;
    logic                          clear;
    logic [DEPTH-1:0][WIDTH-1:0]   data_out;
    logic [DEPTH-1:0]              ext_out;
    logic [CW-1:0]                 count;
    logic                          press_strb;
    logic                          release_strb;
    logic [WIDTH-1:0]              release_code;
    logic                          release_ext;
    logic                          overflow;

    modport master (
        output code_valid, data_in, clear,
        input  data_out, ext_out, count, press_strb, release_strb,
               release_code, release_ext, overflow
    );

    modport slave (
        input  code_valid, data_in, clear,
        output data_out, ext_out, count, press_strb, release_strb,
               release_code, release_ext, overflow
    );
endinterface

// File: rtl/scan_code_history.sv
// Scan-code prefix decoder (E0/F0) feeding a newest-first key press history.
// Latency: all outputs update on the edge that samples code_valid; strobes last one cycle.
// Backpressure: none; when full either the oldest entry drops or the push is rejected.
module scan_code_history #(
    parameter int               DEPTH          = 6,
    parameter int               WIDTH          = 8,
    parameter logic [WIDTH-1:0] BREAK_CODE     = WIDTH'(8'hF0),
    parameter logic [WIDTH-1:0] EXT_CODE       = WIDTH'(8'hE0),
    parameter bit               HOLD_WHEN_FULL = 1'b0
) (
    input  logic                clk,
    input  logic                reset,
    scan_code_history_if.slave  bus
);
    localparam int            CW       = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_EXT     = 2'd1,
        S_BRK     = 2'd2,
        S_EXT_BRK = 2'd3
    } state_t;

    state_t                      state_q, state_nxt;
    logic [DEPTH-1:0][WIDTH-1:0] data_q;
    logic [DEPTH-1:0]            ext_q;
    logic [CW-1:0]               count_q;
    logic                        press_q, rel_strb_q, rel_ext_q, overflow_q;
    logic [WIDTH-1:0]            rel_code_q;

    logic push_req, push_ext, rel_req, rel_ext_nxt, full;

    assign full = (count_q == FULL_CNT);

    always_comb begin
        state_nxt   = state_q;
        push_req    = 1'b0;
        push_ext    = 1'b0;
        rel_req     = 1'b0;
        rel_ext_nxt = 1'b0;
        if (bus.code_valid) begin
            case (state_q)
                S_IDLE: begin
                    if (bus.data_in == EXT_CODE)        state_nxt = S_EXT;
                    else if (bus.data_in == BREAK_CODE) state_nxt = S_BRK;
                    else                                push_req  = 1'b1;
                end
                S_EXT: begin
                    if (bus.data_in == BREAK_CODE) begin
                        state_nxt = S_EXT_BRK;
                    end else if (bus.data_in != EXT_CODE) begin
                        push_req  = 1'b1;
                        push_ext  = 1'b1;
                        state_nxt = S_IDLE;
                    end
                end
                S_BRK: begin
                    rel_req   = 1'b1;
                    state_nxt = S_IDLE;
                end
                default: begin
                    rel_req     = 1'b1;
                    rel_ext_nxt = 1'b1;
                    state_nxt   = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            data_q     <= '0;
            ext_q      <= '0;
            count_q    <= '0;
            press_q    <= 1'b0;
            rel_strb_q <= 1'b0;
            rel_code_q <= '0;
            rel_ext_q  <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            press_q    <= 1'b0;
            rel_strb_q <= 1'b0;
            if (bus.clear) begin
                // release_code/release_ext deliberately survive a clear
                state_q    <= S_IDLE;
                data_q     <= '0;
                ext_q      <= '0;
                count_q    <= '0;
                overflow_q <= 1'b0;
            end else begin
                state_q <= state_nxt;
                if (rel_req) begin
                    rel_strb_q <= 1'b1;
                    rel_code_q <= bus.data_in;
                    rel_ext_q  <= rel_ext_nxt;
                end
                if (push_req) begin
                    if (full) overflow_q <= 1'b1;
                    if (!(full && HOLD_WHEN_FULL)) begin
                        data_q  <= {data_q[DEPTH-2:0], bus.data_in};
                        ext_q   <= {ext_q[DEPTH-2:0], push_ext};
                        press_q <= 1'b1;
                        if (!full) count_q <= count_q + CW'(1);
                    end
                end
            end
        end
    end

    assign bus.data_out     = data_q;
    assign bus.ext_out      = ext_q;
    assign bus.count        = count_q;
    assign bus.press_strb   = press_q;
    assign bus.release_strb = rel_strb_q;
    assign bus.release_code = rel_code_q;
    assign bus.release_ext  = rel_ext_q;
    assign bus.overflow     = overflow_q;
endmodule

// File: tb/tb_scan_code_history.sv
// Bench for scan_code_history: two instances (drop-oldest and hold-when-full) driven in lockstep,
// each checked against its own scoreboard of expected post-edge results.
module tb_scan_code_history;
    localparam int D = 6;
    localparam int W = 8;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    scan_code_history_if #(.DEPTH(D), .WIDTH(W)) a_if ();
    scan_code_history_if #(.DEPTH(D), .WIDTH(W)) b_if ();

    scan_code_history #(.DEPTH(D), .WIDTH(W), .HOLD_WHEN_FULL(1'b0)) dut_a (
        .clk(clk), .reset(reset), .bus(a_if.slave));
    scan_code_history #(.DEPTH(D), .WIDTH(W), .HOLD_WHEN_FULL(1'b1)) dut_b (
        .clk(clk), .reset(reset), .bus(b_if.slave));

    always #5 clk = ~clk;

    typedef struct {
        logic [D-1:0][W-1:0] hist;
        logic [D-1:0]        ext;
        int                  cnt;
        logic                ovf;
        int                  st;
        logic [W-1:0]        rc;
        logic                re;
    } model_t;

    typedef struct {
        logic                press;
        logic                rel;
        logic [D-1:0][W-1:0] hist;
        logic [D-1:0]        ext;
        int                  cnt;
        logic                ovf;
        logic [W-1:0]        rc;
        logic                re;
    } exp_t;

    model_t ma, mb;
    exp_t   sb_a[$];
    exp_t   sb_b[$];
    int     checks = 0;
    int     errors = 0;
    int     press_a = 0, press_b = 0, rel_a = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset(output model_t m);
        m.hist = '0; m.ext = '0; m.cnt = 0; m.ovf = 1'b0;
        m.st = 0; m.rc = '0; m.re = 1'b0;
    endtask

    // Reference behaviour: states 0=IDLE 1=EXT 2=BRK 3=EXT_BRK
    task automatic model_step(inout model_t m, input bit hold, input logic vld,
                              input logic clr, input logic [W-1:0] c, output exp_t e);
        bit do_push = 0;
        bit px = 0;
        e.press = 1'b0;
        e.rel   = 1'b0;
        if (clr) begin
            m.hist = '0; m.ext = '0; m.cnt = 0; m.ovf = 1'b0; m.st = 0;
        end else if (vld) begin
            case (m.st)
                0: if (c == 8'hE0) m.st = 1; else if (c == 8'hF0) m.st = 2; else do_push = 1;
                1: if (c == 8'hF0) m.st = 3;
                   else if (c != 8'hE0) begin do_push = 1; px = 1; m.st = 0; end
                default: begin e.rel = 1'b1; m.rc = c; m.re = (m.st == 3); m.st = 0; end
            endcase
            if (do_push) begin
                if (m.cnt == D) m.ovf = 1'b1;
                if (!(m.cnt == D && hold)) begin
                    m.hist = {m.hist[D-2:0], c};
                    m.ext  = {m.ext[D-2:0], px};
                    e.press = 1'b1;
                    if (m.cnt < D) m.cnt++;
                end
            end
        end
        e.hist = m.hist; e.ext = m.ext; e.cnt = m.cnt; e.ovf = m.ovf; e.rc = m.rc; e.re = m.re;
    endtask

    task automatic cmp(input string p, input exp_t e, input logic press, input logic rel,
                       input logic [D-1:0][W-1:0] h, input logic [D-1:0] x, input int cnt,
                       input logic ovf, input logic [W-1:0] rc, input logic re);
        chk({p, "_press"}, 64'(press), 64'(e.press));
        chk({p, "_rel"},   64'(rel),   64'(e.rel));
        chk({p, "_hist"},  64'(h),     64'(e.hist));
        chk({p, "_ext"},   64'(x),     64'(e.ext));
        chk({p, "_count"}, 64'(cnt),   64'(e.cnt));
        chk({p, "_ovf"},   64'(ovf),   64'(e.ovf));
        chk({p, "_rcode"}, 64'(rc),    64'(e.rc));
        chk({p, "_rext"},  64'(re),    64'(e.re));
    endtask

    task automatic send(input logic vld, input logic clr, input logic [W-1:0] c);
        exp_t ea, eb;
        @(negedge clk);
        a_if.code_valid = vld; a_if.clear = clr; a_if.data_in = c;
        b_if.code_valid = vld; b_if.clear = clr; b_if.data_in = c;
        model_step(ma, 1'b0, vld, clr, c, ea);
        model_step(mb, 1'b1, vld, clr, c, eb);
        sb_a.push_back(ea);
        sb_b.push_back(eb);
        @(posedge clk);
        #1;
        a_if.code_valid = 1'b0; a_if.clear = 1'b0;
        b_if.code_valid = 1'b0; b_if.clear = 1'b0;
        press_a += int'(a_if.press_strb);
        press_b += int'(b_if.press_strb);
        rel_a   += int'(a_if.release_strb);
        chk("sb_nonempty", 64'(sb_a.size() != 0 && sb_b.size() != 0), 64'd1);
        if (sb_a.size() != 0 && sb_b.size() != 0) begin
            ea = sb_a.pop_front();
            eb = sb_b.pop_front();
            cmp("a", ea, a_if.press_strb, a_if.release_strb, a_if.data_out, a_if.ext_out,
                int'(a_if.count), a_if.overflow, a_if.release_code, a_if.release_ext);
            cmp("b", eb, b_if.press_strb, b_if.release_strb, b_if.data_out, b_if.ext_out,
                int'(b_if.count), b_if.overflow, b_if.release_code, b_if.release_ext);
        end
    endtask

    task automatic push(input logic [W-1:0] c);
        send(1'b1, 1'b0, c);
    endtask

    initial begin
        a_if.code_valid = 1'b0; a_if.clear = 1'b0; a_if.data_in = '0;
        b_if.code_valid = 1'b0; b_if.clear = 1'b0; b_if.data_in = '0;
        model_reset(ma);
        model_reset(mb);
        #2 reset = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_data",  64'(a_if.data_out), 64'd0);
        chk("rst_ext",   64'(a_if.ext_out), 64'd0);
        chk("rst_count", 64'(a_if.count), 64'd0);
        chk("rst_ovf",   64'(a_if.overflow), 64'd0);
        chk("rst_strb",  64'({a_if.press_strb, a_if.release_strb}), 64'd0);
        chk("rst_rel",   64'({a_if.release_code, a_if.release_ext}), 64'd0);
        reset = 1'b1;

        // basic pushes
        press_a = 0;
        push(8'h1C); push(8'h32); push(8'h21);
        chk("p3_d0", 64'(a_if.data_out[0]), 64'h21);
        chk("p3_d1", 64'(a_if.data_out[1]), 64'h32);
        chk("p3_d2", 64'(a_if.data_out[2]), 64'h1C);
        chk("p3_count", 64'(a_if.count), 64'd3);
        chk("p3_npress", 64'(press_a), 64'd3);
        chk("p3_ovf", 64'(a_if.overflow), 64'd0);
        send(1'b0, 1'b0, 8'h55);

        // extended press, then extended release
        push(8'hE0); push(8'h75);
        chk("ext_d0", 64'(a_if.data_out[0]), 64'h75);
        chk("ext_e0", 64'(a_if.ext_out[0]), 64'd1);
        rel_a = 0; press_a = 0;
        push(8'hE0); push(8'hF0); push(8'h75);
        chk("erel_code", 64'(a_if.release_code), 64'h75);
        chk("erel_ext", 64'(a_if.release_ext), 64'd1);
        chk("erel_npulse", 64'(rel_a), 64'd1);
        chk("erel_nopush", 64'(press_a), 64'd0);
        send(1'b0, 1'b0, 8'h00);

        // repeated E0 stays in EXT; plain release; F0 as released code
        push(8'hE0); push(8'hE0); push(8'h2A);
        push(8'hF0); push(8'h1C);
        chk("brk_ext", 64'(a_if.release_ext), 64'd0);
        push(8'hF0); push(8'hF0);
        send(1'b0, 1'b1, 8'h00);
        chk("clr_count", 64'(a_if.count), 64'd0);
        chk("clr_keeps_rel", 64'(a_if.release_code), 64'hF0);

        // fill past depth
        press_b = 0;
        for (int i = 1; i <= 7; i++) push(8'(i));
        chk("ovf_a_d0", 64'(a_if.data_out[0]), 64'h07);
        chk("ovf_a_d5", 64'(a_if.data_out[5]), 64'h02);
        chk("ovf_a_count", 64'(a_if.count), 64'd6);
        chk("ovf_a_flag", 64'(a_if.overflow), 64'd1);
        chk("hold_b_d0", 64'(b_if.data_out[0]), 64'h06);
        chk("hold_b_press", 64'(b_if.press_strb), 64'd0);
        chk("hold_b_npress", 64'(press_b), 64'd6);
        chk("hold_b_flag", 64'(b_if.overflow), 64'd1);
        push(8'hE0); push(8'h11);
        chk("hold_b_idle", 64'(b_if.data_out[0]), 64'h06);
        push(8'h22);
        chk("hold_b_fsm_idle_ext", 64'(b_if.ext_out[0]), 64'd0);

        // reset mid-break sequence
        push(8'hF0);
        @(negedge clk);
        reset = 1'b0;
        model_reset(ma);
        model_reset(mb);
        @(negedge clk);
        chk("mrst_count", 64'(a_if.count), 64'd0);
        chk("mrst_rel", 64'(a_if.release_code), 64'd0);
        reset = 1'b1;
        rel_a = 0; press_a = 0;
        push(8'h1C);
        chk("mrst_push", 64'(press_a), 64'd1);
        chk("mrst_norel", 64'(rel_a), 64'd0);
        chk("mrst_d0", 64'(a_if.data_out[0]), 64'h1C);
        press_a = 0;
        send(1'b1, 1'b1, 8'h33);
        chk("clrv_count", 64'(a_if.count), 64'd0);
        chk("clrv_nopush", 64'(press_a), 64'd0);
        send(1'b0, 1'b0, 8'h00);

        chk("sb_drained", 64'(sb_a.size() + sb_b.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
